apb_multi_bridge: RTL and testbench

APB_MULTI_BRIDGE -- requirements
Module: apb_multi_bridge

---
 rtl/apb_multi_bridge.sv | 137 +++++++++++++
 tb/tb_apb_multi_bridge.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_multi_bridge.sv
// APB multi-completer bridge: one upstream request port, NUM_SLV APB completers.
// Optional ACCESS timeout is enabled with macro APB_BRIDGE_TIMEOUT_EN.
module apb_multi_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_SLV = 4,
   parameter int SLV_AW  = 12,
   parameter int TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_wr,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [DATA_W-1:0]         req_wdata,
   input  logic [DATA_W/8-1:0]       req_be,
   output logic                      rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic [ADDR_W-1:0]         paddr,
   output logic [NUM_SLV-1:0]        psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [DATA_W-1:0]         pwdata,
   output logic [DATA_W/8-1:0]       pstrb,
   input  logic [NUM_SLV*DATA_W-1:0] prdata,
   input  logic [NUM_SLV-1:0]        pready,
   input  logic [NUM_SLV-1:0]        pslverr
);

   localparam int IDX_W = $clog2(NUM_SLV);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   req_idx;
   logic               req_hit;
   logic               sel_rdy;
   logic               sel_err;
   logic [DATA_W-1:0]  sel_rdata;

`ifdef APB_BRIDGE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]      to_cnt;
`endif

   // Address decode of the incoming request and mux of the selected completer
   always_comb begin
      req_idx   = req_addr[SLV_AW +: IDX_W];
      req_hit   = (req_addr >> (SLV_AW + IDX_W)) == '0;
      sel_rdy   = pready[idx];
      sel_err   = pslverr[idx];
      sel_rdata = prdata[idx*DATA_W +: DATA_W];
   end

   // Transfer FSM with all APB and response outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         paddr     <= '0;
         psel      <= '0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
         pstrb     <= '0;
`ifdef APB_BRIDGE_TIMEOUT_EN
         to_cnt    <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  if (req_hit) begin
                     idx    <= req_idx;
                     paddr  <= req_addr;
                     pwrite <= req_wr;
                     pwdata <= req_wdata;
                     pstrb  <= req_wr ? req_be : '0;
                     psel   <= NUM_SLV'(1) << req_idx;
                     state  <= SETUP;
                  end else begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                     state     <= RESP;
                  end
               end
            end
            SETUP: begin
               penable <= 1'b1;
`ifdef APB_BRIDGE_TIMEOUT_EN
               to_cnt  <= '0;
`endif
               state   <= ACCESS;
            end
            ACCESS: begin
               if (sel_rdy) begin
                  psel      <= '0;
                  penable   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= sel_err;
                  rsp_rdata <= pwrite ? '0 : sel_rdata;
                  state     <= RESP;
               end
`ifdef APB_BRIDGE_TIMEOUT_EN
               else if (to_cnt == TW'(TIMEOUT - 1)) begin
                  psel      <= '0;
                  penable   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  state     <= RESP;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_multi_bridge.sv
// Directed bench for apb_multi_bridge with a response scoreboard.
// Timeout checks follow macro APB_BRIDGE_TIMEOUT_EN.
module tb_apb_multi_bridge;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid, req_ready, req_wr;
   logic [31:0]  req_addr, req_wdata;
   logic [3:0]   req_be;
   logic         rsp_valid, rsp_err;
   logic [31:0]  rsp_rdata;
   logic [31:0]  paddr, pwdata;
   logic [3:0]   psel, pstrb;
   logic         penable, pwrite;
   logic [127:0] prdata;
   logic [3:0]   pready, pslverr;

   int           cfg_wait = 0;
   logic         cfg_err = 1'b0;
   logic [31:0]  cfg_rdata = '0;
   logic         noise_err = 1'b0;
   int           wcnt = 0;

   int           checks = 0;
   int           errors = 0;
   logic [32:0]  exp_q[$];

   apb_multi_bridge dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 clk = ~clk;

   // Completer model: selected one waits cfg_wait cycles, others emit noise
   always_comb begin
      pready  = '0;
      pslverr = '0;
      prdata  = '0;
      for (int i = 0; i < 4; i++) begin
         if (psel[i]) begin
            pready[i]          = penable && (wcnt >= cfg_wait);
            pslverr[i]         = cfg_err;
            prdata[i*32 +: 32] = cfg_rdata;
         end else begin
            pready[i]          = 1'b1;
            pslverr[i]         = noise_err;
            prdata[i*32 +: 32] = 32'h5555_AAAA;
         end
      end
   end

   // Counts ACCESS cycles for the wait-state model
   always @(posedge clk) begin
      if (psel != 0 && penable) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end

   // Scoreboard: every response must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         logic [32:0] e;
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL rsp_unexpected observed=%h expected=none",
                   {rsp_rdata, rsp_err});
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert ({rsp_rdata, rsp_err} === e) else begin
               errors++;
               $error("FAIL rsp_data_err observed=%h expected=%h",
                      {rsp_rdata, rsp_err}, e);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input string tag, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input int waits,
                       input logic err, input logic [31:0] rd,
                       input logic hit, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_acc,
                       input int exp_lat);
      int   n, lat, acc;
      bit   got, bad_sel;
      logic [3:0] oh;
      oh        = 4'b0001 << addr[13:12];
      cfg_wait  = waits;
      cfg_err   = err;
      cfg_rdata = rd;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wd;
      req_be    = be;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_ready"}, 128'(req_ready), 128'(1));
      exp_q.push_back({exp_rd, exp_err});
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1; acc = 0; got = 0; bad_sel = 0;
      while (!got && lat < 60) begin
         if (penable) acc++;
         if (!hit && psel != 0) bad_sel = 1;
         if (hit && lat == 1)
            chk({tag, "_setup"},
                128'({psel, penable, paddr, pwrite, pwdata, pstrb}),
                128'({oh, 1'b0, addr, wr, wd, wr ? be : 4'h0}));
         if (hit && lat == 2)
            chk({tag, "_access"},
                128'({psel, penable, paddr, pwrite, pwdata, pstrb}),
                128'({oh, 1'b1, addr, wr, wd, wr ? be : 4'h0}));
         if (rsp_valid) begin
            got = 1;
            chk({tag, "_resp_bus_idle"}, 128'({psel, penable}), 128'(0));
         end else begin
            @(posedge clk); #1; lat++;
         end
      end
      chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
      chk({tag, "_access_cycles"}, 128'(acc), 128'(exp_acc));
      if (!hit) chk({tag, "_no_psel"}, 128'(bad_sel), 128'(0));
      @(posedge clk); #1;
      chk({tag, "_rsp_one_cycle"}, 128'(rsp_valid), 128'(0));
      chk({tag, "_rsp_hold"}, 128'({rsp_rdata, rsp_err}),
          128'({exp_rd, exp_err}));
   endtask

   initial begin
      bit quiet;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      rst_n     = 1'b1;
      #2 rst_n  = 1'b0;
      #1;
      chk("reset_outputs",
          128'({req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable,
                pwrite, paddr, pwdata, pstrb}), 128'(0));
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("ready_before_edge", 128'(req_ready), 128'(0));
      @(posedge clk); #1;
      chk("ready_after_release", 128'(req_ready), 128'(1));

      xfer("wr_c1", 1'b1, 32'h0000_1004, 32'hA5A5_5A5A, 4'hF, 0, 1'b0,
           32'h0, 1'b1, 32'h0, 1'b0, 1, 3);
      xfer("rd_c3_wait2", 1'b0, 32'h0000_3010, 32'h1111_2222, 4'hF, 2, 1'b0,
           32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0, 3, 5);
      xfer("rd_miss", 1'b0, 32'h0001_0000, 32'h0, 4'hF, 0, 1'b0,
           32'h0, 1'b0, 32'h0, 1'b1, 0, 1);
      noise_err = 1'b1;
      xfer("wr_c2_slverr", 1'b1, 32'h0000_2008, 32'h0BAD_F00D, 4'h6, 0, 1'b1,
           32'h0, 1'b1, 32'h0, 1'b1, 1, 3);
      xfer("rd_c0_noise", 1'b0, 32'h0000_0ffc, 32'h0, 4'h3, 1, 1'b0,
           32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0, 2, 4);
      noise_err = 1'b0;
      xfer("wr_miss_hi", 1'b1, 32'h8000_2000, 32'hFFFF_FFFF, 4'hF, 0, 1'b0,
           32'h0, 1'b0, 32'h0, 1'b1, 0, 1);
      xfer("rd_c2", 1'b0, 32'h0000_2abc, 32'h0, 4'h0, 0, 1'b0,
           32'hCAFE_0042, 1'b1, 32'hCAFE_0042, 1'b0, 1, 3);

      // Reset while a read sits in ACCESS: transfer is dropped silently
      cfg_wait  = 1000;
      req_wr    = 1'b0;
      req_addr  = 32'h0000_0020;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("abort_in_access", 128'({psel, penable}), 128'({4'b0001, 1'b1}));
      #2 rst_n = 1'b0;
      #1;
      chk("abort_outputs_zero",
          128'({req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable,
                pwrite, paddr, pwdata, pstrb}), 128'(0));
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_ready_after_release", 128'(req_ready), 128'(1));
      cfg_wait = 0;

`ifdef APB_BRIDGE_TIMEOUT_EN
      xfer("rd_timeout", 1'b0, 32'h0000_1040, 32'h0, 4'hF, 1000, 1'b0,
           32'h7777_7777, 1'b1, 32'h0, 1'b1, 16, 18);
`else
      // Without the timeout the bridge waits as long as the completer does
      cfg_wait  = 1000;
      req_addr  = 32'h0000_1040;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      quiet = 1;
      for (int i = 0; i < 102; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) quiet = 0;
      end
      chk("no_timeout_quiet", 128'(quiet), 128'(1));
      chk("no_timeout_access", 128'({psel, penable}), 128'({4'b0010, 1'b1}));
      rst_n = 1'b0;
      #1;
      chk("no_timeout_abort", 128'({psel, penable, rsp_valid}), 128'(0));
      @(negedge clk) rst_n = 1'b1;
      cfg_wait = 0;
      @(posedge clk); #1;
`endif
      xfer("wr_c3_after", 1'b1, 32'h0000_3000, 32'h0102_0304, 4'h1, 0, 1'b0,
           32'h0, 1'b1, 32'h0, 1'b0, 1, 3);
      repeat (2) @(posedge clk);
      chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
